// File: rtl/batch_sum_pkg.sv
// rtl/batch_sum_pkg.sv - shared types and defaults for batch_sum_compare
package batch_sum_pkg;

  localparam int WIDTH_D = 3;
  localparam int BATCH_D = 4;
  localparam int ACC_W_D = 6;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_t;

endpackage

// File: rtl/ripple_add.sv
// rtl/ripple_add.sv - parameterised N-bit ripple-carry adder
module ripple_add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] w_c;

  assign w_c[0] = cin;

  // one full adder per bit, carry chained from LSB to MSB
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[N];

endmodule

// File: rtl/batch_sum_compare.sv
// rtl/batch_sum_compare.sv - batch accumulator with threshold compare
module batch_sum_compare
  import batch_sum_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int BATCH = BATCH_D,
  parameter int ACC_W = ACC_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt
);

  localparam int CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_in_ready;
  logic             w_out_valid;

  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic [ACC_W-1:0] r_total;
  logic             r_out_ovf;
  cmp_t             r_cmp;
  cmp_t             w_cmp;

  logic [WIDTH-1:0] w_pair_lo;
  logic             w_pair_hi;
  logic [ACC_W-1:0] w_pair_ext;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_acc_cout;
  logic             w_ovf_next;
  logic             w_hs;
  logic             w_last;

  ripple_add #(.N(WIDTH)) u_pair_add (
    .a    (in_a),
    .b    (in_b),
    .cin  (1'b0),
    .sum  (w_pair_lo),
    .cout (w_pair_hi)
  );

  assign w_pair_ext = {{(ACC_W-WIDTH-1){1'b0}}, w_pair_hi, w_pair_lo};

  ripple_add #(.N(ACC_W)) u_acc_add (
    .a    (r_acc),
    .b    (w_pair_ext),
    .cin  (1'b0),
    .sum  (w_acc_next),
    .cout (w_acc_cout)
  );

  assign w_ovf_next = r_ovf | w_acc_cout;
  assign w_hs       = in_valid & w_in_ready;
  assign w_last     = (r_cnt == CNT_W'(BATCH-1));

  // three-way compare of the closing total against the current threshold
  always_comb begin
    w_cmp    = '0;
    w_cmp.lt = (w_acc_next <  thresh);
    w_cmp.eq = (w_acc_next == thresh);
    w_cmp.gt = (w_acc_next >  thresh);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_next;
  end

  // next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ACCUM: begin
        w_in_ready = 1'b1;
        if (w_hs && w_last) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase
  end

  // accumulate pairs, latch the result at batch close, clear on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_total   <= '0;
      r_out_ovf <= 1'b0;
      r_cmp     <= '0;
    end else if (r_state == DONE) begin
      if (out_ready) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
        r_total   <= '0;
        r_out_ovf <= 1'b0;
        r_cmp     <= '0;
      end
    end else if (w_hs) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
      r_ovf <= w_ovf_next;
      if (w_last) begin
        r_total   <= w_acc_next;
        r_out_ovf <= w_ovf_next;
        r_cmp     <= w_cmp;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_total = r_total;
  assign out_ovf   = r_out_ovf;
  assign out_lt    = r_cmp.lt;
  assign out_eq    = r_cmp.eq;
  assign out_gt    = r_cmp.gt;

endmodule
